// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Branch prediction and resolution unit for the MIPS pipeline.
//   Fetch side: a direct-mapped BTB with per-entry 2-bit saturating counters
//   produces a registered next-PC prediction one cycle after each lookup.
//   Execute side: resolved branches train the table and raise a registered
//   one-cycle mispredict pulse with the correct redirect PC.
//
//   After reset an init sweep clears one entry per cycle (ENTRIES cycles,
//   busy high) before normal operation starts.
//
//   Optional macro BP_STATS_EN adds saturating branch/mispredict counters
//   (ports stat_clr, stat_branches, stat_mispredicts).
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   busy                init sweep in progress
//   req_valid, req_pc   fetch lookup request
//   pred_valid/taken/target  registered prediction
//   upd_*               resolved instruction from execute
//   mispredict, redirect_pc  registered redirect to the PC mux
module branch_predict_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_W    = 8,
  parameter int unsigned CTR_INIT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            busy,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_is_branch,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_idx;

  logic             tbl_valid [ENTRIES];
  logic [TAG_W-1:0] tbl_tag   [ENTRIES];
  logic [1:0]       tbl_ctr   [ENTRIES];
  logic [XLEN-3:0]  tbl_tgt   [ENTRIES];

  // Lookup (reads pre-update contents; the write lands at the same edge)
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_hit;
  logic             lk_taken;
  logic [XLEN-1:0]  lk_target;

  always_comb begin
    req_idx   = req_pc[IDX_W+1:2];
    req_tag   = req_pc[TAG_W+IDX_W+1:IDX_W+2];
    req_hit   = tbl_valid[req_idx] && (tbl_tag[req_idx] == req_tag);
    // Stale valid bits can survive a mid-sweep reset, so gate on RUN.
    lk_taken  = (state == S_RUN) && req_hit && tbl_ctr[req_idx][1];
    lk_target = lk_taken ? {tbl_tgt[req_idx], 2'b00} : req_pc + XLEN'(4);
  end

  // Update / init-sweep write port
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       wr_ctr;
  logic [XLEN-3:0]  wr_tgt;

  always_comb begin
    upd_idx  = upd_pc[IDX_W+1:2];
    upd_tag  = upd_pc[TAG_W+IDX_W+1:IDX_W+2];
    upd_hit  = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
    upd_ctr  = tbl_ctr[upd_idx];
    wr_en    = 1'b0;
    wr_idx   = upd_idx;
    wr_valid = tbl_valid[upd_idx];
    wr_tag   = tbl_tag[upd_idx];
    wr_ctr   = upd_ctr;
    wr_tgt   = tbl_tgt[upd_idx];
    if (state == S_INIT) begin
      wr_en    = 1'b1;
      wr_idx   = sweep_idx;
      wr_valid = 1'b0;
      wr_tag   = '0;
      wr_ctr   = 2'(CTR_INIT);
      wr_tgt   = '0;
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        if (upd_hit) begin
          wr_en = 1'b1;
          if (upd_taken) begin
            wr_ctr = (upd_ctr == 2'd3) ? 2'd3 : upd_ctr + 2'd1;
            wr_tgt = upd_target[XLEN-1:2];
          end else begin
            wr_ctr = (upd_ctr == 2'd0) ? 2'd0 : upd_ctr - 2'd1;
          end
        end else if (upd_taken) begin
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          wr_tag   = upd_tag;
          wr_ctr   = 2'd2;
          wr_tgt   = upd_target[XLEN-1:2];
        end
      end else if (upd_hit) begin
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_valid[wr_idx] <= wr_valid;
      tbl_tag[wr_idx]   <= wr_tag;
      tbl_ctr[wr_idx]   <= wr_ctr;
      tbl_tgt[wr_idx]   <= wr_tgt;
    end
  end

  // Mispredict detection
  logic            mp_next;
  logic [XLEN-1:0] redir_next;

  always_comb begin
    mp_next    = upd_valid && ((upd_taken != upd_pred_taken) ||
                               (upd_taken && (upd_target != upd_pred_target)));
    redir_next = upd_taken ? upd_target : upd_pc + XLEN'(4);
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      sweep_idx   <= '0;
      busy        <= 1'b1;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      pred_valid  <= req_valid;
      pred_taken  <= lk_taken;
      pred_target <= lk_target;
      mispredict  <= mp_next;
      if (upd_valid) redirect_pc <= redir_next;
      case (state)
        S_INIT: begin
          if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
            state     <= S_RUN;
            busy      <= 1'b0;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if ((state == S_RUN) && upd_valid && upd_is_branch && (stat_branches != '1))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
